// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 operator keypad scanner.
package keypad_pkg;

    localparam int unsigned KEY_ROWS   = 4;
    localparam int unsigned KEY_COLS   = 4;
    localparam int unsigned FRAME_BITS = KEY_ROWS * KEY_COLS;

    // Debounce state machine.
    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD,
        RELEASE
    } scan_state_t;

    // Result of classifying one complete scan frame.
    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_class_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and host-side signals of the keypad scanner.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KEY_ROWS-1:0] key_rows;      // active-low, pulled up
    logic [KEY_COLS-1:0] key_cols;      // active-low column drive
    logic [3:0]          key_code;      // row*4 + col
    logic                key_valid;
    logic                key_held;
    logic                multiple_keys;

    modport master (
        input  key_rows,
        output key_cols,
        output key_code,
        output key_valid,
        output key_held,
        output multiple_keys
    );

    modport slave (
        output key_rows,
        input  key_cols,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  multiple_keys
    );

endinterface

// File: rtl/keypad_scanner_frame_classifier.sv
// Combinational classification of one 16-bit scan frame: popcount plus key encode.
module scan_frame_classifier
    import keypad_pkg::*;
(
    input  logic [FRAME_BITS-1:0] frame,
    output frame_class_t          frame_class,
    output logic [3:0]            code
);

    logic [4:0] count;

    // Count pressed keys; code holds the lowest set bit, which is the key when exactly one is set.
    always_comb begin
        count       = '0;
        code        = '0;
        frame_class = NONE;
        for (int i = FRAME_BITS - 1; i >= 0; i--) begin
            if (frame[i]) begin
                count = count + 5'd1;
                code  = 4'(i);
            end
        end
        if (count == 5'd0) begin
            frame_class = NONE;
        end else if (count == 5'd1) begin
            frame_class = SINGLE;
        end else begin
            frame_class = MULTI;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column ring scan, frame capture and whole-frame debounce.
// SCAN_DIVIDER must be >= 4 and DEBOUNCE_SCANS >= 1.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIVIDER   = 16,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input logic              clock,
    input logic              reset_n,
    input logic              enable,
    keypad_scanner_if.master kp
);

    localparam int unsigned PRESC_W = $clog2(SCAN_DIVIDER);
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(SCAN_DIVIDER - 1);
    // Count value that, with one more qualifying frame, completes the debounce.
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(DEBOUNCE_SCANS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [1:0]            rst_sync_q;
    logic                  rst_n_int;
    logic [KEY_ROWS-1:0]   rows_meta_q;
    logic [KEY_ROWS-1:0]   rows_sync_q;
    logic [PRESC_W-1:0]    presc_q;
    logic [1:0]            col_q;
    logic [1:0]            col_d;
    logic [KEY_COLS-1:0]   key_cols_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] frame_d;
    logic                  tick;
    logic                  frame_done;
    frame_class_t          frame_class;
    logic [3:0]            frame_code;

    scan_state_t           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            cand_q;
    logic [3:0]            key_code_q;
    logic                  key_valid_q;
    logic                  key_held_q;
    logic                  multi_q;

    // Reset assertion is immediate; release is delayed two clocks to stay synchronous.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Two-flop synchronizer for the asynchronous row inputs (idle level is all-high).
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rows_meta_q <= '1;
            rows_sync_q <= '1;
        end else begin
            rows_meta_q <= kp.key_rows;
            rows_sync_q <= rows_meta_q;
        end
    end

    assign tick       = enable && (presc_q == '0);
    assign frame_done = tick && (col_q == 2'd3);
    assign col_d      = tick ? col_q + 2'd1 : col_q;

    // Frame buffer with the current column's rows merged in (1 = pressed).
    always_comb begin
        frame_d = frame_q;
        for (int r = 0; r < KEY_ROWS; r++) begin
            frame_d[{2'(r), col_q}] = ~rows_sync_q[r];
        end
    end

    scan_frame_classifier u_classifier (
        .frame       (frame_d),
        .frame_class (frame_class),
        .code        (frame_code)
    );

    // Prescaler, column ring and frame capture; disable parks everything at column 0.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            presc_q    <= '0;
            col_q      <= '0;
            frame_q    <= '0;
            key_cols_q <= '1;
        end else if (!enable) begin
            presc_q    <= '0;
            col_q      <= '0;
            frame_q    <= '0;
            key_cols_q <= '1;
        end else begin
            key_cols_q <= ~(4'b0001 << col_d);
            col_q      <= col_d;
            if (tick) begin
                presc_q <= PRESC_RELOAD;
                frame_q <= frame_d;
            end else begin
                presc_q <= presc_q - 1'b1;
            end
        end
    end

    // Debounce FSM, stepped once per complete frame, with registered outputs.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (!enable) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
                multi_q    <= 1'b0;
            end else if (frame_done) begin
                multi_q <= (frame_class == MULTI);
                unique case (state_q)
                    IDLE: begin
                        if (frame_class == SINGLE) begin
                            cand_q <= frame_code;
                            cnt_q  <= CNT_W'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q     <= HELD;
                                key_code_q  <= frame_code;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                state_q <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (frame_class == SINGLE && frame_code == cand_q) begin
                            if (cnt_q >= CNT_LAST) begin
                                state_q     <= HELD;
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end
                            cnt_q <= sat_inc(cnt_q);
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    HELD: begin
                        if (!(frame_class == SINGLE && frame_code == key_code_q)) begin
                            key_held_q <= 1'b0;
                            if (frame_class == NONE) begin
                                cnt_q   <= CNT_W'(1);
                                // A single quiet frame already completes the release.
                                state_q <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                            end else begin
                                cnt_q   <= '0;
                                state_q <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (frame_class == NONE) begin
                            if (cnt_q >= CNT_LAST) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= sat_inc(cnt_q);
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign kp.key_cols      = key_cols_q;
    assign kp.key_code      = key_code_q;
    assign kp.key_valid     = key_valid_q;
    assign kp.key_held      = key_held_q;
    assign kp.multiple_keys = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: membrane keypad model, frame-level reference model,
// directed scenarios followed by randomized frames.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int unsigned SD        = 4;
    localparam int unsigned DB        = 3;
    localparam int          FRAME_CYC = 4 * SD;
    localparam logic [15:0] COL0_KEYS = 16'h1111;
    localparam logic [15:0] K0        = 16'h0001;
    localparam logic [15:0] K5        = 16'h0020;
    localparam logic [15:0] K6        = 16'h0040;
    localparam logic [15:0] K9        = 16'h0200;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic [15:0] pressed = '0;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIVIDER   (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .kp      (kp)
    );

    always #5 clock = ~clock;

    // Membrane model: a row is pulled low by any pressed key whose column is driven low.
    always_comb begin
        kp.key_rows = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp.key_cols[c]) kp.key_rows[r] = 1'b0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model, one step per complete frame.
    bit m_held;
    bit m_releasing;
    bit m_multi;
    int m_key;
    int m_cand;
    int m_run;
    int m_quiet;

    task automatic model_idle();
        m_held      = 1'b0;
        m_releasing = 1'b0;
        m_multi     = 1'b0;
        m_run       = 0;
        m_quiet     = 0;
    endtask

    task automatic model_frame(input logic [15:0] f, output bit pulse);
        int n;
        int code;
        n     = $countones(f);
        code  = -1;
        pulse = 1'b0;
        for (int i = 0; i < 16; i++) if (f[i]) code = i;
        m_multi = (n > 1);
        if (m_held) begin
            if (!(n == 1 && code == m_key)) begin
                m_held      = 1'b0;
                m_releasing = 1'b1;
                m_quiet     = (n == 0) ? 1 : 0;
                if (m_quiet >= DB) m_releasing = 1'b0;
            end
        end else if (m_releasing) begin
            if (n == 0) begin
                m_quiet++;
                if (m_quiet >= DB) m_releasing = 1'b0;
            end else begin
                m_quiet = 0;
            end
        end else begin
            if (m_run == 0) begin
                if (n == 1) begin
                    m_cand = code;
                    m_run  = 1;
                end
            end else if (n == 1 && code == m_cand) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= DB) begin
                m_held = 1'b1;
                m_key  = m_cand;
                m_run  = 0;
                pulse  = 1'b1;
            end
        end
    endtask

    // Hold `mask` for one frame, wait for the column-0 restart that ends it, then compare.
    // `first` marks the frame right after (re)start, whose column 0 is never driven.
    task automatic run_frame(input logic [15:0] mask, input bit first, input string tag);
        int          cycles;
        int          pulses;
        bit          seen;
        bit          pulse_exp;
        logic [3:0]  prev;
        cycles  = 0;
        pulses  = 0;
        seen    = 1'b0;
        prev    = kp.key_cols;
        pressed = mask;
        while (!seen && cycles < 8 * FRAME_CYC) begin
            @(posedge clock);
            #1;
            cycles++;
            if (kp.key_cols == 4'b1110 && prev != 4'b1110) seen = 1'b1;
            else pulses += int'(kp.key_valid);
            prev = kp.key_cols;
        end
        check({tag, " frame end"}, 32'(seen), 32'd1);
        if (!first) check({tag, " frame length"}, 32'(cycles), 32'(FRAME_CYC));
        model_frame(first ? (mask & ~COL0_KEYS) : mask, pulse_exp);
        check({tag, " key_valid"}, 32'(kp.key_valid), 32'(pulse_exp));
        check({tag, " stray key_valid"}, 32'(pulses), 32'd0);
        check({tag, " key_held"}, 32'(kp.key_held), 32'(m_held));
        check({tag, " multiple_keys"}, 32'(kp.multiple_keys), 32'(m_multi));
        check({tag, " key_code"}, 32'(kp.key_code), 32'(m_key));
    endtask

    task automatic frames(input logic [15:0] mask, input int n, input string tag);
        for (int i = 0; i < n; i++) run_frame(mask, 1'b0, tag);
    endtask

    task automatic disable_and_check(input string tag);
        enable = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check({tag, " off key_cols"}, 32'(kp.key_cols), 32'hF);
        check({tag, " off key_held"}, 32'(kp.key_held), 32'd0);
        check({tag, " off multiple_keys"}, 32'(kp.multiple_keys), 32'd0);
        check({tag, " off key_code"}, 32'(kp.key_code), 32'(m_key));
        model_idle();
    endtask

    initial begin
        logic [15:0] cur;
        int          sel;

        // Reset values.
        repeat (3) @(posedge clock);
        #1;
        check("rst key_cols", 32'(kp.key_cols), 32'hF);
        check("rst key_code", 32'(kp.key_code), 32'd0);
        check("rst key_valid", 32'(kp.key_valid), 32'd0);
        check("rst key_held", 32'(kp.key_held), 32'd0);
        check("rst multiple_keys", 32'(kp.multiple_keys), 32'd0);
        model_idle();
        m_key   = 0;
        reset_n = 1'b1;
        enable  = 1'b1;
        run_frame('0, 1'b1, "start");

        // Clean press of row 1 / col 2, then release.
        frames(K6, 6, "clean");
        frames('0, 3, "clean rel");

        // Bounce: one frame, gap, three frames.
        frames(K6, 1, "bounce a");
        frames('0, 1, "bounce gap");
        frames(K6, 3, "bounce b");
        frames('0, 3, "bounce rel");

        // Two keys down, then one of them released.
        frames(K0 | K5, 2, "multi");
        frames(K0, 3, "multi single");
        frames('0, 3, "multi rel");

        // No rollover from key 6 to key 9.
        frames(K6, 3, "roll hold");
        frames(K6 | K9, 1, "roll both");
        frames(K9, 3, "roll nine");
        frames('0, 3, "roll rel");
        frames(K9, 3, "roll repress");
        frames('0, 3, "roll rel2");

        // Disable while held, re-enable with the key still down.
        frames(K6, 3, "dis hold");
        disable_and_check("dis");
        enable = 1'b1;
        run_frame(K6, 1'b1, "dis restart");
        frames(K6, 2, "dis again");
        frames('0, 3, "dis rel");

        // Reset in the middle of a confirm sequence.
        frames(K6, 1, "rst confirm");
        repeat (5) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid rst key_cols", 32'(kp.key_cols), 32'hF);
        check("mid rst key_code", 32'(kp.key_code), 32'd0);
        check("mid rst key_valid", 32'(kp.key_valid), 32'd0);
        check("mid rst key_held", 32'(kp.key_held), 32'd0);
        check("mid rst multiple_keys", 32'(kp.multiple_keys), 32'd0);
        pressed = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_idle();
        m_key = 0;
        run_frame('0, 1'b1, "rst restart");
        frames('0, 3, "rst quiet");

        // Randomized frames with sticky key patterns and occasional disables.
        cur = '0;
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel >= 5 && sel < 7) cur = '0;
            else if (sel >= 7 && sel < 9) cur = 16'd1 << $urandom_range(0, 15);
            else if (sel == 9)
                cur = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) begin
                disable_and_check("rand");
                enable = 1'b1;
                run_frame(cur, 1'b1, "rand restart");
            end else begin
                run_frame(cur, 1'b0, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Operator keypad front end for the irrigation controller. It drives a 4x4 membrane keypad column by column with a ring-style scan, samples the returning rows, debounces whole scan frames, and reports one debounced key code per press. It mirrors the LED matrix path: the matrix driver writes a multiplexed grid, and this block reads one. Its outputs feed the setpoint and mode logic beside the existing sensor inputs.

## Interface
- SCAN_DIVIDER, default 16: clock cycles each column is driven. Must be ≥ 4.
- DEBOUNCE_SCANS, default 3: number of consecutive identical scan frames required to accept a press, and also to accept a release. Must be ≥ 1.
- clock  input  1  system clock. All logic runs in this one clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  scanning enable. When low, the block is held idle.
- key_rows  input  4  keypad rows. Active-low, externally pulled up, asynchronous to clock.
- key_cols  output  4  keypad column drive. Active-low and one-hot-low while scanning.
- key_code  output  4  last accepted key, encoded as row*4 + col.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key is still held.
- multiple_keys  output  1  high when the last complete frame had more than one key down.

## Operation
- key_rows passes through a two-flop synchronizer before any use.
- Prescaler:
  - Counts down from SCAN_DIVIDER-1. A tick fires when it reaches 0, then it reloads.
  - Prescaler width is $clog2(SCAN_DIVIDER).
- Column scan:
  - A 2-bit column index selects the column to drive.
  - On each tick, the synchronized rows are sampled into 4 bits of a 16-bit frame buffer (bit = row*4+col, 1 = pressed). Then the index advances 0→1→2→3→0 and key_cols updates.
- Frame classification happens on the tick that samples column 3, using the complete frame:
  - NONE: no bits set.
  - SINGLE(code): exactly one bit set.
  - MULTI: two or more bits set.
  - multiple_keys is updated to (class == MULTI) on every frame.
- State machine. States: IDLE, CONFIRM, HELD, RELEASE. The frame counter is $clog2(DEBOUNCE_SCANS+1) bits wide and saturates.
  - IDLE:
    - SINGLE(c): go to CONFIRM, candidate = c, count = 1.
    - Anything else: stay in IDLE.
  - CONFIRM:
    - SINGLE(candidate): count++.
    - When count reaches DEBOUNCE_SCANS: go to HELD, key_code = candidate, key_valid pulses.
    - Any other frame: go back to IDLE.
  - HELD:
    - SINGLE(key_code): stay in HELD.
    - Any other frame (NONE, a different key, MULTI): go to RELEASE with count = 1 if the frame was NONE, else count = 0.
  - RELEASE:
    - NONE: count++. When count reaches DEBOUNCE_SCANS, go to IDLE.
    - Any other frame: count = 0 and stay in RELEASE. There is no rollover; a new key needs a full release first.
  - When DEBOUNCE_SCANS = 1, the press is accepted on the first SINGLE frame: IDLE goes directly to HELD.
- key_held is 1 exactly while the state is HELD.
- enable low:
  - key_cols = 1111; the prescaler and column index are cleared to 0.
  - State goes to IDLE; key_held = 0 and multiple_keys = 0.
  - key_code is retained.
  - When enable rises again, scanning restarts at column 0 with an empty frame.

## Timing
- Reset values: key_cols 1111, key_code 0000, key_valid 0, key_held 0, multiple_keys 0. State IDLE, prescaler 0, column index 0, frame buffer 0.
- The reset_n assert takes effect immediately, including mid-frame or mid-debounce. Deassert is released synchronously through a two-flop reset synchronizer.
- Column dwell is SCAN_DIVIDER cycles; one frame is 4*SCAN_DIVIDER cycles.
- Each row sample is taken at the end of its column's dwell. This gives at least SCAN_DIVIDER-2 cycles of settling after synchronizer delay.
- key_valid, key_held and multiple_keys are registered and change in the cycle after the column-3 tick.
- Press latency: DEBOUNCE_SCANS frames, from the first complete frame containing the key, plus 1 cycle.
- If a tick coincides with enable falling, enable wins and no sample is taken.

## Structure
- Package keypad_pkg holds:
  - KEY_ROWS = 4 and KEY_COLS = 4.
  - Enum scan_state_t {IDLE, CONFIRM, HELD, RELEASE}.
  - Enum frame_class_t {NONE, SINGLE, MULTI}.
- Sub-module scan_frame_classifier: a combinational block taking the 16-bit frame and producing frame_class_t plus a 4-bit code. It does the popcount and priority encode.

## Test plan
All scenarios run with SCAN_DIVIDER = 4 and DEBOUNCE_SCANS = 3.
- **Reset:** pull reset_n low mid-CONFIRM → all outputs take their reset values immediately and key_cols = 1111; after release, the scan restarts at column 0 and no key_valid appears.
- **Clean press:** hold row 1 / col 2 for 6 frames → exactly one key_valid pulse, key_code = 6 one cycle after the 3rd matching frame; key_held = 1 until release; 3 NONE frames return the block to IDLE.
- **Bounce:** press key 6 for 1 frame, release 1 frame, press for 3 frames → a single key_valid, after the final 3rd frame.
- **Multiple keys:** keys 0 and 5 down → multiple_keys = 1 and no key_valid; release key 5 → multiple_keys = 0, then key_valid with key_code = 0 after 3 frames.
- **No rollover:** hold key 6, add key 9 → state RELEASE and key_held = 0; release only key 6 → no pulse for key 9 until all keys are up for 3 frames and key 9 is pressed again.
- **Disable while held:** drop enable while HELD → key_cols = 1111, key_held = 0, key_code stays 6; re-enable with key 6 still held → a new key_valid after 3 frames.
